dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive store grants issued while a load is waiting.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ld_req  input  1  load request from the memory unit.
REQ-005 ld_addr  input  32  load byte address.
REQ-006 ld_rmask  input  4  load byte read mask, already shifted to lane.
REQ-007 ld_ready  output  1  load accepted this cycle.
REQ-008 ld_resp  output  1  load completion pulse.
REQ-009 ld_rdata  output  32  load data, valid with ld_resp.
REQ-010 flush  input  1  squash any in-flight load.
REQ-011 st_req  input  1  committed-store request from ROB head.
REQ-012 st_addr  input  32  store byte address.
REQ-013 st_wmask  input  4  store write mask, lane-shifted.
REQ-014 st_wdata  input  32  store data, lane-aligned.
REQ-015 st_ready  output  1  store accepted this cycle.
REQ-016 st_resp  output  1  store completion pulse.
REQ-017 dmem_addr  output  32  memory word address.
REQ-018 dmem_rmask  output  4  memory read mask.
REQ-019 dmem_wmask  output  4  memory write mask.
REQ-020 dmem_wdata  output  32  memory write data.
REQ-021 dmem_rdata  input  32  memory read data.
REQ-022 dmem_resp  input  1  memory completion.
REQ-023 busy  output  1  high in any state other than IDLE.

Function
REQ-024 FSM states: IDLE, LD_WAIT, ST_WAIT, LD_DROP, ZERO_ACK; one transaction outstanding at most.
REQ-025 ld_ready/st_ready combinational; only asserted in IDLE; at most one high per cycle; acceptance = req && ready.
REQ-026 Arbitration in IDLE: store wins when both requested, unless starve counter == STARVE_LIMIT, then load wins.
REQ-027 Starve counter (width clog2(STARVE_LIMIT+1)): +1 on each store grant while ld_req high; cleared on load grant; saturates at STARVE_LIMIT.
REQ-028 On acceptance, dmem_* registered next edge: dmem_addr = {addr[31:2],2'b00}; load -> rmask=ld_rmask, wmask=0, wdata=0; store -> rmask=0, wmask=st_wmask, wdata=st_wdata.
REQ-029 dmem_rmask/dmem_wmask nonzero for exactly one cycle per transaction, then 0; dmem_addr/dmem_wdata held until next acceptance.
REQ-030 Transitions: IDLE->LD_WAIT on load accept; IDLE->ST_WAIT on store accept; LD_WAIT/ST_WAIT -> IDLE on dmem_resp.
REQ-031 In LD_WAIT, dmem_resp -> ld_resp=1, ld_rdata=dmem_rdata same cycle (combinational); ld_rdata=0 otherwise.
REQ-032 In ST_WAIT, dmem_resp -> st_resp=1 same cycle.
REQ-033 dmem_resp in the acceptance cycle (IDLE) is ignored; earliest legal response is cycle after mask pulse.
REQ-034 No new acceptance in cycle of dmem_resp; next acceptance earliest cycle after (one bubble).
REQ-035 flush in LD_WAIT (without dmem_resp same cycle) -> LD_DROP; LD_DROP waits for dmem_resp, returns to IDLE, no ld_resp.
REQ-036 flush coincident with dmem_resp in LD_WAIT -> ld_resp suppressed, IDLE next.
REQ-037 flush in IDLE blocks load acceptance that cycle; store still eligible; flush does not affect ST_WAIT.
REQ-038 Zero-mask request (ld_rmask==0 or st_wmask==0) accepted normally, no dmem mask pulse, -> ZERO_ACK; ZERO_ACK asserts matching resp one cycle (ld_rdata=0), -> IDLE; flush in ZERO_ACK suppresses ld_resp.
REQ-039 dmem_resp in IDLE or ZERO_ACK ignored, no state change.

Reset
REQ-040 rst asserted at any time: state=IDLE, starve counter=0, dmem_addr/rmask/wmask/wdata=0, all resp/ready/busy outputs 0 while rst high.
REQ-041 Reset mid-transaction abandons it; later stray dmem_resp produces no ld_resp/st_resp.

Verification
REQ-042 Load: ld_req, addr 0x1000_0006, rmask 4'b1100 -> next cycle dmem_addr 0x1000_0004, dmem_rmask 1100 for one cycle; dmem_resp with rdata 0xDEAD_BEEF 3 cycles later -> ld_resp=1, ld_rdata 0xDEAD_BEEF same cycle.
REQ-043 Simultaneous ld_req/st_req held continuously, STARVE_LIMIT=4, 1-cycle memory -> 4 store grants then 1 load grant, pattern repeats.
REQ-044 Flush: load accepted, flush 1 cycle later, dmem_resp 2 cycles after -> no ld_resp, busy drops after resp, store accepted next cycle.
REQ-045 Zero mask: st_req wmask 0 -> no dmem_wmask pulse, st_resp one cycle after acceptance.
REQ-046 Async reset in ST_WAIT (between clock edges) -> outputs 0 immediately; dmem_resp after release -> no st_resp, state IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the load unit and committed stores.
// One transaction in flight; stores win ties until a waiting load has been passed over STARVE_LIMIT times.
module dmem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_req,
   input  logic [31:0] ld_addr,
   input  logic [3:0]  ld_rmask,
   output logic        ld_ready,
   output logic        ld_resp,
   output logic [31:0] ld_rdata,
   input  logic        flush,
   input  logic        st_req,
   input  logic [31:0] st_addr,
   input  logic [3:0]  st_wmask,
   input  logic [31:0] st_wdata,
   output logic        st_ready,
   output logic        st_resp,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_rmask,
   output logic [3:0]  dmem_wmask,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_resp,
   output logic        busy
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE,
      LD_WAIT,
      ST_WAIT,
      LD_DROP,
      ZERO_ACK
   } state_t;

   state_t        state_reg, state_next;
   logic [SW-1:0] starve_reg, starve_next;
   logic          zero_ld_reg, zero_ld_next;
   logic [31:0]   addr_reg, wdata_reg;
   logic [3:0]    rmask_reg, wmask_reg;
   logic          at_limit, st_win, ld_acc, st_acc;
   logic          unused_addr_lsbs;

   // Byte offsets are dropped: memory is word addressed and masks are pre-shifted.
   assign unused_addr_lsbs = ^{ld_addr[1:0], st_addr[1:0]};

   assign at_limit = (starve_reg == SW'(STARVE_LIMIT));
   assign st_win   = st_req && !(ld_req && !flush && at_limit);
   assign st_ready = !rst && (state_reg == IDLE) && st_win;
   assign ld_ready = !rst && (state_reg == IDLE) && !flush && !st_win;
   assign ld_acc   = ld_req && ld_ready;
   assign st_acc   = st_req && st_ready;
   assign busy     = (state_reg != IDLE);

   assign dmem_addr  = addr_reg;
   assign dmem_rmask = rmask_reg;
   assign dmem_wmask = wmask_reg;
   assign dmem_wdata = wdata_reg;

   always_comb begin
      state_next   = state_reg;
      zero_ld_next = zero_ld_reg;
      ld_resp      = 1'b0;
      st_resp      = 1'b0;
      ld_rdata     = 32'h0;
      case (state_reg)
         IDLE: begin
            if (st_acc) begin
               state_next   = (st_wmask == 4'h0) ? ZERO_ACK : ST_WAIT;
               zero_ld_next = 1'b0;
            end else if (ld_acc) begin
               state_next   = (ld_rmask == 4'h0) ? ZERO_ACK : LD_WAIT;
               zero_ld_next = 1'b1;
            end
         end
         LD_WAIT: begin
            if (dmem_resp) begin
               state_next = IDLE;
               if (!flush) begin
                  ld_resp  = 1'b1;
                  ld_rdata = dmem_rdata;
               end
            end else if (flush) begin
               state_next = LD_DROP;
            end
         end
         ST_WAIT: begin
            if (dmem_resp) begin
               st_resp    = 1'b1;
               state_next = IDLE;
            end
         end
         LD_DROP: begin
            if (dmem_resp) begin
               state_next = IDLE;
            end
         end
         ZERO_ACK: begin
            state_next = IDLE;
            if (zero_ld_reg) begin
               ld_resp = !flush;
            end else begin
               st_resp = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A store only counts against the load while the load is actually asking.
   always_comb begin
      starve_next = starve_reg;
      if (ld_acc) begin
         starve_next = '0;
      end else if (st_acc && ld_req && !at_limit) begin
         starve_next = starve_reg + SW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         starve_reg  <= '0;
         zero_ld_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         starve_reg  <= starve_next;
         zero_ld_reg <= zero_ld_next;
      end
   end

   // Masks pulse for the single cycle after acceptance; address and data persist.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg  <= 32'h0;
         wdata_reg <= 32'h0;
         rmask_reg <= 4'h0;
         wmask_reg <= 4'h0;
      end else if (ld_acc) begin
         addr_reg  <= {ld_addr[31:2], 2'b00};
         wdata_reg <= 32'h0;
         rmask_reg <= ld_rmask;
         wmask_reg <= 4'h0;
      end else if (st_acc) begin
         addr_reg  <= {st_addr[31:2], 2'b00};
         wdata_reg <= st_wdata;
         rmask_reg <= 4'h0;
         wmask_reg <= st_wmask;
      end else begin
         rmask_reg <= 4'h0;
         wmask_reg <= 4'h0;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_dmem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_req, flush, st_req, dmem_resp;
   logic [31:0] ld_addr, st_addr, st_wdata, dmem_rdata;
   logic [3:0]  ld_rmask, st_wmask;
   logic        ld_ready, ld_resp, st_ready, st_resp, busy;
   logic [31:0] ld_rdata, dmem_addr, dmem_wdata;
   logic [3:0]  dmem_rmask, dmem_wmask;

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_rmask(ld_rmask),
      .ld_ready(ld_ready), .ld_resp(ld_resp), .ld_rdata(ld_rdata),
      .flush(flush),
      .st_req(st_req), .st_addr(st_addr), .st_wmask(st_wmask), .st_wdata(st_wdata),
      .st_ready(st_ready), .st_resp(st_resp),
      .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
      .busy(busy)
   );

   int errors = 0;
   int checks = 0;

   // Model: the outstanding transaction (kind 0 none, 1 load, 2 store) and its attributes.
   int          m_kind, m_age, m_starve;
   bit          m_zero, m_drop;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_rmask, m_wmask;
   bit          e_acc_ld, e_acc_st;
   bit          auto_mem;
   int          mem_mode;
   int          grants[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_kind = 0; m_age = 0; m_starve = 0; m_zero = 0; m_drop = 0;
      m_addr = 0; m_wdata = 0; m_rmask = 0; m_wmask = 0;
   endtask

   task automatic clear_inputs();
      ld_req = 0; st_req = 0; flush = 0; dmem_resp = 0;
      ld_addr = 0; st_addr = 0; st_wdata = 0; dmem_rdata = 0;
      ld_rmask = 0; st_wmask = 0;
   endtask

   // Called at posedge+1: drives memory if automatic, then checks everything at the negedge.
   task automatic settle();
      bit idle, ld_ok, st_wins, x_st_ready, x_ld_ready, x_ld_resp, x_st_resp, legal;
      logic [31:0] x_rdata;
      if (auto_mem) begin
         legal = (m_kind != 0) && !m_zero && (m_age >= 2);
         if (mem_mode == 0) dmem_resp = legal;
         else if (legal) dmem_resp = ($urandom_range(0, 2) == 0);
         else if (m_kind == 0 || m_zero) dmem_resp = ($urandom_range(0, 7) == 0);
         else dmem_resp = 0;
         dmem_rdata = $urandom;
      end
      #4;
      idle       = (m_kind == 0);
      ld_ok      = ld_req && !flush;
      st_wins    = idle && st_req && !(ld_ok && m_starve == LIMIT);
      x_st_ready = st_wins;
      x_ld_ready = idle && !flush && !st_wins;
      x_ld_resp  = (m_kind == 1) && !m_drop && !flush && (m_zero || dmem_resp);
      x_st_resp  = (m_kind == 2) && (m_zero || dmem_resp);
      x_rdata    = (x_ld_resp && !m_zero) ? dmem_rdata : 32'h0;
      e_acc_ld   = x_ld_ready && ld_req;
      e_acc_st   = x_st_ready && st_req;
      check("ld_ready", ld_ready, x_ld_ready);
      check("st_ready", st_ready, x_st_ready);
      check("ld_resp", ld_resp, x_ld_resp);
      check("ld_rdata", ld_rdata, x_rdata);
      check("st_resp", st_resp, x_st_resp);
      check("busy", busy, !idle);
      check("dmem_addr", dmem_addr, m_addr);
      check("dmem_rmask", dmem_rmask, m_rmask);
      check("dmem_wmask", dmem_wmask, m_wmask);
      check("dmem_wdata", dmem_wdata, m_wdata);
      if (ld_req && ld_ready) grants.push_back(1);
      if (st_req && st_ready) grants.push_back(2);
   endtask

   // Applies this cycle's inputs to the model, then moves to posedge+1.
   task automatic advance();
      if (m_kind != 0) begin
         if (m_zero || dmem_resp) m_kind = 0;
         else if (m_kind == 1 && flush) m_drop = 1;
         m_age++;
      end
      m_rmask = 0;
      m_wmask = 0;
      if (e_acc_ld) begin
         m_kind = 1; m_zero = (ld_rmask == 0); m_drop = 0; m_age = 1; m_starve = 0;
         m_addr = {ld_addr[31:2], 2'b00}; m_rmask = ld_rmask; m_wdata = 0;
      end else if (e_acc_st) begin
         m_kind = 2; m_zero = (st_wmask == 0); m_drop = 0; m_age = 1;
         if (ld_req && m_starve < LIMIT) m_starve++;
         m_addr = {st_addr[31:2], 2'b00}; m_wmask = st_wmask; m_wdata = st_wdata;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic do_reset();
      clear_inputs();
      auto_mem = 0;
      rst = 1;
      ld_req = 1; st_req = 1;
      @(posedge clk);
      #1;
      check("rst_ld_ready", ld_ready, 1'b0);
      check("rst_st_ready", st_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_dmem_addr", dmem_addr, 32'h0);
      check("rst_masks", {dmem_rmask, dmem_wmask}, 8'h0);
      clear_inputs();
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
   endtask

   initial begin
      clear_inputs();
      model_reset();
      auto_mem = 0;
      mem_mode = 0;
      do_reset();

      // Basic load with a three-cycle memory response.
      ld_req = 1; ld_addr = 32'h1000_0006; ld_rmask = 4'b1100;
      settle();
      check("t1_ld_ready", ld_ready, 1'b1);
      advance();
      ld_req = 0;
      settle();
      check("t1_addr", dmem_addr, 32'h1000_0004);
      check("t1_rmask", dmem_rmask, 4'b1100);
      advance();
      settle();
      check("t1_rmask_off", dmem_rmask, 4'b0000);
      advance();
      step();
      dmem_resp = 1; dmem_rdata = 32'hDEAD_BEEF;
      settle();
      check("t1_ld_resp", ld_resp, 1'b1);
      check("t1_ld_rdata", ld_rdata, 32'hDEAD_BEEF);
      advance();
      dmem_resp = 0;
      step();

      // Continuous contention with a one-cycle memory: four stores per load.
      do_reset();
      grants.delete();
      auto_mem = 1; mem_mode = 0;
      ld_req = 1; ld_addr = 32'h2000_0000; ld_rmask = 4'hF;
      st_req = 1; st_addr = 32'h3000_0008; st_wmask = 4'h3; st_wdata = 32'h1234_5678;
      for (int i = 0; i < 45; i++) step();
      check("t2_grant_count", (grants.size() >= 15), 1'b1);
      for (int i = 0; i < 15 && i < grants.size(); i++)
         check($sformatf("t2_grant%0d", i), grants[i], (i % 5 == 4) ? 1 : 2);

      // Flush one cycle after load acceptance, memory answers two cycles later.
      do_reset();
      ld_req = 1; ld_addr = 32'h0000_0100; ld_rmask = 4'h1;
      step();
      ld_req = 0; flush = 1;
      step();
      flush = 0;
      step();
      dmem_resp = 1; dmem_rdata = 32'hCAFE_F00D;
      settle();
      check("t3_no_ld_resp", ld_resp, 1'b0);
      check("t3_busy_during", busy, 1'b1);
      advance();
      dmem_resp = 0; st_req = 1; st_addr = 32'h0000_0200; st_wmask = 4'hF; st_wdata = 32'hA5A5_A5A5;
      settle();
      check("t3_busy_after", busy, 1'b0);
      check("t3_st_ready", st_ready, 1'b1);
      advance();
      st_req = 0;
      auto_mem = 1; mem_mode = 0;
      for (int i = 0; i < 4; i++) step();

      // Zero-mask store completes without touching memory.
      do_reset();
      st_req = 1; st_addr = 32'h0000_0040; st_wmask = 4'h0; st_wdata = 32'h5555_0000;
      settle();
      check("t4_st_ready", st_ready, 1'b1);
      advance();
      st_req = 0;
      settle();
      check("t4_no_wmask", dmem_wmask, 4'h0);
      check("t4_st_resp", st_resp, 1'b1);
      advance();
      settle();
      check("t4_idle", busy, 1'b0);
      advance();

      // Asynchronous reset while a store waits; a late memory reply is ignored.
      do_reset();
      st_req = 1; st_addr = 32'h0000_0080; st_wmask = 4'hF; st_wdata = 32'h7777_8888;
      step();
      st_req = 0;
      settle();
      #2;
      rst = 1;
      #1;
      check("t5_busy", busy, 1'b0);
      check("t5_wmask", dmem_wmask, 4'h0);
      check("t5_addr", dmem_addr, 32'h0);
      check("t5_wdata", dmem_wdata, 32'h0);
      check("t5_ready", {ld_ready, st_ready}, 2'b00);
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
      dmem_resp = 1;
      settle();
      check("t5_no_st_resp", st_resp, 1'b0);
      check("t5_state_idle", busy, 1'b0);
      advance();
      dmem_resp = 0;

      // Random traffic with variable memory latency and stray responses.
      auto_mem = 1; mem_mode = 1;
      for (int i = 0; i < 1500; i++) begin
         ld_req   = ($urandom_range(0, 2) != 0);
         st_req   = $urandom_range(0, 1);
         flush    = ($urandom_range(0, 5) == 0);
         ld_addr  = $urandom;
         st_addr  = $urandom;
         st_wdata = $urandom;
         ld_rmask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
         st_wmask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
